// File: rtl/fifo_stream_reader.sv
// Pop-side adapter for the circular-buffer fifo: turns its registered data_out
// into a valid/ready stream through a 2-entry holding buffer.
module fifo_stream_reader #(
  parameter int WIDTH     = 16,
  parameter int CNT_WIDTH = 16,
  parameter int DEBUG     = 0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  output logic                 fifo_pop,
  input  logic [WIDTH-1:0]     fifo_data,
  input  logic                 fifo_empty,
  output logic                 fifo_flush,
  input  logic                 flush,
  output logic                 out_valid,
  output logic [WIDTH-1:0]     out_data,
  input  logic                 out_ready,
  output logic [CNT_WIDTH-1:0] delivered
);

  logic [1:0][WIDTH-1:0] hold_q;
  logic                  rd_ptr;
  logic                  wr_ptr;
  logic [1:0]            count;
  logic                  inflight;

  logic                  deq;
  logic                  deq_ok;
  logic                  capture;
  logic [2:0]            occ;
  logic [2:0]            count_nxt;

  assign out_valid  = (count != 2'd0);
  assign out_data   = hold_q[rd_ptr];
  assign fifo_flush = flush;

  assign deq     = out_valid && out_ready;
  assign deq_ok  = deq && !flush;
  assign capture = inflight && !flush;

  // Slots committed after this cycle: buffered + word in flight - word leaving.
  assign occ       = {1'b0, count} + {2'b00, inflight} - {2'b00, deq};
  assign fifo_pop  = !fifo_empty && !flush && rst_n && (occ < 3'd2);
  assign count_nxt = {1'b0, count} + {2'b00, capture} - {2'b00, deq_ok};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count     <= 2'd0;
      inflight  <= 1'b0;
      rd_ptr    <= 1'b0;
      wr_ptr    <= 1'b0;
      delivered <= '0;
    end else if (flush) begin
      count    <= 2'd0;
      inflight <= 1'b0;
      rd_ptr   <= 1'b0;
      wr_ptr   <= 1'b0;
    end else begin
      inflight <= fifo_pop;
      count    <= count_nxt[1:0];
      if (capture) wr_ptr <= ~wr_ptr;
      if (deq_ok) begin
        rd_ptr    <= ~rd_ptr;
        delivered <= delivered + CNT_WIDTH'(1);
      end
    end
  end

  // Data storage needs no reset; out_data is only meaningful with out_valid.
  always_ff @(posedge clk) begin
    if (capture) hold_q[wr_ptr] <= fifo_data;
  end

  a_no_overflow : assert property (@(posedge clk) disable iff (!rst_n)
    count_nxt <= 3'd2);

  generate
    if (DEBUG != 0) begin : g_dbg
      always_ff @(posedge clk) begin
        if (rst_n) begin
          if (fifo_pop) $display("%m pop");
          if (deq_ok)   $display("%m out %x", out_data);
          if (flush)    $display("%m flush");
        end
      end
    end
  endgenerate

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Bench for fifo_stream_reader: queue-based fifo model feeding the DUT and a
// scoreboard monitor checking delivered order, hold, capacity and counter.
module tb_fifo_stream_reader;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        fifo_pop;
  logic [15:0] fifo_data = '0;
  logic        fifo_empty;
  logic        fifo_flush;
  logic        flush = 1'b0;
  logic        out_valid;
  logic [15:0] out_data;
  logic        out_ready = 1'b0;
  logic [15:0] delivered;

  always #5 clk = ~clk;

  fifo_stream_reader #(.WIDTH(16), .CNT_WIDTH(16), .DEBUG(0)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .fifo_pop   (fifo_pop),
    .fifo_data  (fifo_data),
    .fifo_empty (fifo_empty),
    .fifo_flush (fifo_flush),
    .flush      (flush),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .out_ready  (out_ready),
    .delivered  (delivered)
  );

  logic [15:0] fq[$];
  logic [15:0] exp_q[$];
  int          fq_n = 0;
  int          n_tests = 0;
  int          n_fail = 0;
  int          ref_del = 0;
  int          occ = 0;
  bit          prev_hold = 1'b0;
  logic [15:0] hold_data = '0;
  logic [15:0] mon_e;
  bit          pop_s = 1'b0;
  bit          flush_s = 1'b0;

  assign fifo_empty = flush || (fq_n == 0);

  function automatic void chk(input bit ok, input string nm, input int act, input int exp);
    n_tests++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endfunction

  // Source fifo model: registered data_out one cycle after an accepted pop.
  always @(posedge clk) begin
    if (flush_s) fq.delete();
    else if (pop_s && rst_n && fq.size() > 0) fifo_data <= fq.pop_front();
    fq_n = fq.size();
  end

  // Monitor/scoreboard, sampled mid-cycle.
  always @(negedge clk) begin
    pop_s   = fifo_pop;
    flush_s = flush;
    if (!rst_n) begin
      prev_hold = 1'b0;
      occ       = 0;
    end else if (flush) begin
      chk(fifo_flush === 1'b1 && fifo_pop === 1'b0, "flush_cycle", {fifo_flush, fifo_pop}, 2);
      exp_q.delete();
      occ       = 0;
      prev_hold = 1'b0;
    end else begin
      if (prev_hold)
        chk(out_valid === 1'b1 && out_data === hold_data, "hold_stable", out_data, hold_data);
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) chk(1'b0, "unexpected_word", out_data, 0);
        else begin
          mon_e = exp_q.pop_front();
          chk(out_data === mon_e, "data_order", out_data, mon_e);
        end
        chk(delivered === 16'(ref_del), "delivered_cnt", delivered, ref_del & 16'hffff);
        ref_del++;
      end
      occ = occ + int'(fifo_pop) - int'(out_valid && out_ready);
      if (fifo_pop) begin
        chk(!fifo_empty, "pop_when_empty", fifo_empty, 0);
        chk(occ <= 2, "capacity", occ, 2);
      end
      prev_hold = out_valid && !out_ready;
      hold_data = out_data;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [15:0] w);
    fq.push_back(w);
    fq_n = fq.size();
    exp_q.push_back(w);
  endtask

  task automatic drain(input int max);
    for (int i = 0; i < max; i++) begin
      if (exp_q.size() == 0 && fq_n == 0 && !out_valid) break;
      tick();
    end
    chk(exp_q.size() == 0 && !out_valid, "drain_done", exp_q.size(), 0);
  endtask

  initial begin
    int pc, vc, fd, ld, np, sent, found;

    // Reset state (async, no clock edge needed)
    #2 rst_n = 1'b0;
    #2;
    chk(out_valid === 1'b0, "reset_valid", out_valid, 0);
    chk(fifo_pop === 1'b0, "reset_pop", fifo_pop, 0);
    chk(delivered === 16'd0, "reset_delivered", delivered, 0);
    tick();
    rst_n = 1'b1;

    // 1: streaming with ready high
    out_ready = 1'b1;
    tick();
    for (int i = 1; i <= 4; i++) push(16'(i));
    pc = -1; vc = -1; fd = -1; ld = -1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (fifo_pop && pc < 0) pc = i;
      if (out_valid && vc < 0) vc = i;
      if (out_valid && out_ready) begin
        if (fd < 0) fd = i;
        ld = i;
      end
    end
    chk(vc - pc == 2, "first_latency", vc - pc, 2);
    chk(ld - fd == 3, "back_to_back", ld - fd, 3);
    chk(delivered === 16'd4, "stream_delivered", delivered, 4);

    // 2: backpressure
    tick();
    out_ready = 1'b0;
    for (int i = 1; i <= 4; i++) push(16'(i));
    np = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      np += int'(fifo_pop);
    end
    chk(np == 2, "bp_pops", np, 2);
    chk(out_valid === 1'b1 && out_data === 16'h0001, "bp_head", out_data, 1);
    tick();
    out_ready = 1'b1;
    drain(30);
    chk(delivered === 16'd8, "bp_delivered", delivered, 8);

    // 3: toggling ready
    tick();
    for (int i = 0; i < 6; i++) push(16'h0010 + 16'(i));
    for (int i = 0; i < 40; i++) begin
      if (exp_q.size() == 0 && fq_n == 0) break;
      out_ready = (i % 2 == 0);
      tick();
    end
    out_ready = 1'b1;
    drain(10);
    chk(delivered === 16'd14, "toggle_delivered", delivered, 14);

    // 4: flush with one word buffered and one in flight
    out_ready = 1'b0;
    tick();
    for (int i = 0; i < 4; i++) push(16'h0020 + 16'(i));
    found = 0;
    for (int i = 0; i < 10 && !found; i++) begin
      @(negedge clk);
      if (fifo_pop) found = 1;
    end
    chk(found == 1, "flush_first_pop", found, 1);
    @(posedge clk);
    tick();
    flush = 1'b1;
    @(negedge clk);
    chk(fifo_flush === 1'b1, "flush_passthru", fifo_flush, 1);
    tick();
    flush = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk(out_valid === 1'b0 && fifo_pop === 1'b0, "post_flush_idle", {out_valid, fifo_pop}, 0);
    end
    chk(delivered === 16'd14, "flush_keeps_cnt", delivered, 14);
    tick();
    out_ready = 1'b1;
    push(16'h0030);
    push(16'h0031);
    drain(20);
    chk(delivered === 16'd16, "post_flush_cnt", delivered, 16);

    // 5: async reset mid-stream with full buffer
    out_ready = 1'b0;
    tick();
    for (int i = 0; i < 4; i++) push(16'h0040 + 16'(i));
    repeat (5) @(posedge clk);
    #1;
    chk(out_valid === 1'b1 && delivered === 16'd16, "pre_reset", delivered, 16);
    #2 rst_n = 1'b0;
    #1;
    chk(out_valid === 1'b0, "mid_reset_valid", out_valid, 0);
    chk(fifo_pop === 1'b0, "mid_reset_pop", fifo_pop, 0);
    chk(delivered === 16'd0, "mid_reset_cnt", delivered, 0);
    fq.delete(); fq_n = 0; exp_q.delete(); ref_del = 0;
    tick();
    tick();
    rst_n = 1'b1;

    // 6: counter wrap over 70000 deliveries
    out_ready = 1'b1;
    sent = 0;
    for (int c = 0; c < 80000 && sent < 70000; c++) begin
      tick();
      if (fq_n < 3) begin
        push(16'($urandom));
        sent++;
      end
    end
    drain(20);
    chk(delivered === 16'd4464, "wrap", delivered, 4464);

    // 7: random traffic with occasional flushes
    for (int i = 0; i < 400; i++) begin
      tick();
      out_ready = 1'($urandom_range(0, 1));
      flush     = ($urandom_range(0, 39) == 0);
      if (fq_n < 6 && $urandom_range(0, 1) == 1) push(16'($urandom));
    end
    tick();
    flush = 1'b0;
    out_ready = 1'b1;
    drain(40);
    chk(delivered === 16'(ref_del), "random_cnt", delivered, ref_del & 16'hffff);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/fifo_stream_reader.md
Name: fifo_stream_reader

Overview:
- Pop-side companion to the team's synchronous circular-buffer fifo. Drives its pop/flush inputs, consumes its registered data_out, and re-presents entries as a valid/ready stream for downstream consumers (decode, issue, memory response paths).
- Hides the fifo's one-cycle pop-to-data latency behind a 2-entry holding buffer. Sustains 1 word/cycle, never drops a popped word, never pops a word it cannot hold.

Parameters:
- WIDTH, 16, bits per entry; must match the attached fifo.
- CNT_WIDTH, 16, width of the delivered-word counter.
- DEBUG, 0, nonzero enables $display trace of pops, deliveries and flushes.

Ports:
- clk  input  1  single clock, all state on posedge.
- rst_n  input  1  asynchronous active-low reset.
- fifo_pop  output  1  to fifo pop.
- fifo_data  input  WIDTH  from fifo data_out; valid the cycle after an accepted pop.
- fifo_empty  input  1  from fifo q_empty; combinational, forced 1 during flush.
- fifo_flush  output  1  to fifo flush.
- flush  input  1  pipeline flush request.
- out_valid  output  1  out_data holds a deliverable word.
- out_data  output  WIDTH  oldest buffered word.
- out_ready  input  1  consumer accepts this cycle.
- delivered  output  CNT_WIDTH  count of words handed off.

Behaviour:
- Reset (rst_n low, async): buffer count=0, inflight=0, rd/wr pointers=0, delivered=0.
- Reset gives out_valid=0 and fifo_pop=0. out_data is don't-care while out_valid=0.
- Reset asserted mid-transfer discards buffered and in-flight words. No pop is issued while rst_n is low.
- State:
  - 2-entry buffer with 1-bit rd/wr pointers and a 2-bit count (0..2).
  - inflight flag: a pop was accepted last cycle.
- deq = out_valid && out_ready. out_valid = (count != 0).
- fifo_pop = !fifo_empty && !flush && rst_n && (count + inflight - deq) < 2.
  - fifo_pop is combinational. No combinational path from fifo_data to any output.
- inflight <= fifo_pop.
- Capture: if inflight && !flush, write fifo_data to buf[wr] and advance wr.
- Dequeue: on deq && !flush, advance rd and increment delivered (wraps modulo 2^CNT_WIDTH).
- Count update:
  - count <= count + capture - deq.
  - Capture and deq in the same cycle leave count unchanged; this is legal at count 1 or 2.
- Latency:
  - Word at fifo head with buffer empty: pop at cycle t, out_valid at t+2.
  - Steady state with out_ready held high: one word per cycle.
- Backpressure:
  - out_ready low holds out_valid and out_data stable; fifo_pop drops once count+inflight reaches 2.
  - Count never exceeds 2. Reaching 3 is an assertion failure.
- Flush:
  - fifo_flush = flush, combinational passthrough.
  - On a flush cycle: no pop, no capture (in-flight word discarded), no deq counted.
  - Next edge: count=0, inflight=0, pointers=0. out_valid=0 from the following cycle.
  - delivered is not cleared by flush.
- Empty fifo: fifo_pop stays 0. Buffered words still drain.
- Ordering: words leave in exactly the fifo pop order; pointers wrap 1->0.
- DEBUG: when DEBUG is nonzero, $display "%m pop", "%m out %x", and "%m flush".

Test Plan:
- Reset, then push 0x0001..0x0004 into the fifo with out_ready=1 -> out_data 0x0001..0x0004 on 4 consecutive cycles. First out_valid 2 cycles after the first pop. delivered=4.
- out_ready=0 with 4 words queued -> exactly 2 pops, count=2, out_data=0x0001 held stable. Raise out_ready -> remaining words delivered in order, no duplicates or losses.
- out_ready toggling 1,0,1,0 over a 6-word stream -> delivered sequence identical to push order. Pops never exceed the consumer's capacity.
- Assert flush for 1 cycle while inflight=1 and count=1 -> fifo_flush=1 that cycle. Next cycle out_valid=0 and fifo_pop=0 until new pushes arrive. delivered unchanged.
- Pull rst_n low mid-stream with count=2 -> out_valid, fifo_pop and delivered read 0 immediately, before any clock edge.
- Run 70000 deliveries with CNT_WIDTH=16 -> delivered wraps to 70000-65536=4464.
